pipe_decode: RTL and testbench



---
 rtl/pipe_decode.sv | 80 ++++++++
 tb/tb_pipe_decode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_decode.sv
// pipe_decode
//   Decoder for words produced by the 8-bit add-one stage chain and its final
//   doubling stage. An encoded word y = 2*(x + DEPTH) mod 256 is recovered as
//   x = ((y >> 1) - DEPTH) mod 256 by an elastic pipeline of DEPTH+1 stages.
//   Stage 0 halves the word and stages 1..DEPTH each subtract 1. The pipeline
//   stalls as a whole when the output is valid and downstream is not ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data holds an encoded word
//   in_ready   block accepts in_data this cycle (independent of in_valid)
//   in_data    encoded word y
//   out_valid  out_data/out_err hold a decoded word
//   out_ready  downstream accepts the output this cycle
//   out_data   decoded word
//   out_err    the encoded word was odd (its LSB was 1)
//   count      output handshakes since reset, saturating at all-ones
module pipe_decode #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [7:0] data;
  } stage_t;

  // stg[0] is the halving stage; stg[DEPTH] drives the outputs.
  stage_t stg [DEPTH+1];

  logic stall;

  // A valid word parked at the output freezes every stage, bubbles included.
  assign stall     = stg[DEPTH].valid & ~out_ready;
  assign in_ready  = ~stall;

  assign out_valid = stg[DEPTH].valid;
  assign out_data  = stg[DEPTH].data;
  assign out_err   = stg[DEPTH].err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data/err fields are cleared as well as the valid bits so the
      // output reads 0x00 straight after reset; the stage array is small flops,
      // not a RAM, so resetting it is cheap.
      for (int k = 0; k <= DEPTH; k++) begin
        stg[k] <= '0;
      end
      count <= '0;
    end else begin
      if (!stall) begin
        // NOTE: non-blocking assignments make every stage sample its
        // predecessor's pre-edge value, so the loop order does not matter.
        stg[0] <= '{valid: in_valid, err: in_data[0], data: {1'b0, in_data[7:1]}};
        for (int k = 1; k <= DEPTH; k++) begin
          stg[k] <= '{valid: stg[k-1].valid,
                      err:   stg[k-1].err,
                      data:  stg[k-1].data - 8'd1};
        end
      end
      if (stg[DEPTH].valid && out_ready && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode
//   Self-checking bench for pipe_decode (DEPTH=8, CNT_W=16). A transaction
//   level model tracks accepted words in a queue, each tagged with the number
//   of non-stalled edges it has seen; a word is due at the output once it has
//   seen DEPTH+1 of them. Directed scenarios are followed by random traffic
//   and a counter saturation run.
module tb_pipe_decode;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_err;
  logic [CNT_W-1:0] count;

  pipe_decode #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         age;
  } item_t;

  item_t      mq[$];        // accepted words still inside the block
  logic [8:0] obs_q[$];     // DUT outputs {err, data} seen at handshakes
  int         m_count;
  bit         last_acc;
  bit         check_en = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_valid();
    return (mq.size() > 0) && (mq[0].age == DEPTH + 1);
  endfunction

  // Applies one rising edge to the model using the inputs held over it.
  task automatic model_edge();
    bit vld;
    item_t it;
    vld = exp_valid();
    last_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_count = 0;
    end else if (!(vld && !out_ready)) begin
      if (vld) begin
        void'(mq.pop_front());
        if (m_count < (1 << CNT_W) - 1) m_count++;
      end
      foreach (mq[i]) mq[i].age++;
      if (in_valid) begin
        it.d   = 8'(int'(in_data >> 1) - DEPTH);
        it.e   = in_data[0];
        it.age = 1;
        mq.push_back(it);
        last_acc = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit vld;
    vld = exp_valid();
    check("out_valid", {31'b0, out_valid}, {31'b0, vld});
    check("in_ready", {31'b0, in_ready}, {31'b0, ~(vld & ~out_ready)});
    if (vld) begin
      check("out_data", {24'b0, out_data}, {24'b0, mq[0].d});
      check("out_err", {31'b0, out_err}, {31'b0, mq[0].e});
    end
    check("count", {16'b0, count}, m_count);
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    rst_n     = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    if (r && out_valid && rdy) obs_q.push_back({out_err, out_data});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (check_en) compare();
  endtask

  task automatic feed(input logic [7:0] w);
    int tries;
    tries = 0;
    do begin
      step(1'b1, 1'b1, w, 1'b1);
      tries++;
    end while (!last_acc && tries < 50);
    if (!last_acc) check("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_obs(input string tag, input logic [8:0] exp);
    if (obs_q.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      check(tag, {23'b0, obs_q.pop_front()}, {23'b0, exp});
    end
  endtask

  initial begin
    int idx;
    int bp_left;
    logic rdy;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_out_data", {24'b0, out_data}, 32'h00);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic: 0x10 -> 0x00 visible after edge t+8, counted one edge later
    obs_q.delete();
    step(1'b1, 1'b1, 8'h10, 1'b1);
    drain(7);
    check("basic_early", {31'b0, out_valid}, 32'd0);
    drain(1);
    check("basic_valid", {31'b0, out_valid}, 32'd1);
    check("basic_data", {24'b0, out_data}, 32'h00);
    drain(1);
    check("basic_count", {16'b0, count}, 32'd1);
    check_obs("basic_obs", 9'h000);

    // Streaming and wrap-around
    feed(8'h00); feed(8'h12); feed(8'hFE); feed(8'h20);
    drain(12);
    check_obs("wrap0", 9'h0F8);
    check_obs("wrap1", 9'h001);
    check_obs("wrap2", 9'h077);
    check_obs("wrap3", 9'h008);
    check("stream_count", {16'b0, count}, 32'd5);

    // Error flag
    feed(8'h11); feed(8'h12);
    drain(12);
    check_obs("err_odd", 9'h100);
    check_obs("err_even", 9'h001);

    // Back-pressure: hold out_ready low for 5 cycles once output appears
    obs_q.delete();
    idx = 0;
    bp_left = 5;
    for (int c = 0; c < 40; c++) begin
      rdy = 1'b1;
      if (out_valid && bp_left > 0) begin
        rdy = 1'b0;
        bp_left--;
      end
      step(1'b1, idx < 8, 8'(8'h10 + 2 * idx), rdy);
      if (last_acc) idx++;
      if (!rdy) begin
        check("bp_hold_data", {24'b0, out_data}, 32'h00);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
    end
    check("bp_all_sent", idx, 32'd8);
    check("bp_out_count", obs_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check_obs("bp_order", 9'(i));

    // Reset mid-flight
    obs_q.delete();
    feed(8'h20); feed(8'h22); feed(8'h24);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_count", {16'b0, count}, 32'd0);
    drain(12);
    check("midrst_no_stale", obs_q.size(), 32'd0);
    feed(8'h14);
    drain(8);
    check("midrst_new_valid", {31'b0, out_valid}, 32'd1);
    check("midrst_new_data", {24'b0, out_data}, 32'h02);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 2) != 0,
           8'($urandom), $urandom_range(0, 3) != 0);
    end
    drain(12);
    check("rand_drained", mq.size(), 32'd0);

    // Counter saturation
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check_en = 1'b0;
    for (int c = 0; c < 65540; c++) step(1'b1, 1'b1, 8'(c), 1'b1);
    drain(12);
    check_en = 1'b1;
    drain(1);
    check("sat_count", {16'b0, count}, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
